sand_tile_sequencer: RTL and testbench

SAND_TILE_SEQUENCER -- requirements
Module: sand_tile_sequencer

---
 rtl/sand_tile_sequencer.sv | 142 ++++++++++++++
 tb/tb_sand_tile_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sand_tile_sequencer.sv
// Tile sequencer for a sand-automaton grid: fetches each tile, hands it to the compute stage,
// writes the result to the opposite RAM bank, then flips banks once per generation.
module sand_tile_sequencer #(
  parameter int ROWS       = 128,
  parameter int COLS       = 128,
  parameter int ROWS_TILE  = 4,
  parameter int COLS_TILE  = 4,
  parameter int CELL_WIDTH = 3,
  localparam int TILE_SIZE = ROWS_TILE * COLS_TILE,
  localparam int TILES     = ROWS * COLS / TILE_SIZE,
  localparam int TILE_W    = TILE_SIZE * CELL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_req,
  input  logic [TILE_W-1:0] tile_rdata,
  input  logic              cmp_ready,
  input  logic              res_valid,
  input  logic [TILE_W-1:0] res_tile,
  output logic [9:0]        tile_addr,
  output logic              read_tile,
  output logic              write_tile,
  output logic              reset_tile,
  output logic              read_ram_a,
  output logic [TILE_W-1:0] tile_wdata,
  output logic              cmp_valid,
  output logic [TILE_W-1:0] cmp_tile,
  output logic              busy,
  output logic              done,
  output logic              stable,
  output logic [15:0]       gen_count
);

  // state | meaning: IDLE wait | CLEAR zero write bank | RD_ADDR/RD_CAP fetch tile |
  // CMP_REQ/CMP_WAIT compute handshake | WRITE store tile | SWAP flip banks, end generation
  typedef enum logic [2:0] {
    IDLE, CLEAR, RD_ADDR, RD_CAP, CMP_REQ, CMP_WAIT, WRITE, SWAP
  } state_t;

  localparam logic [9:0] LAST_IDX = 10'(TILES - 1);

  state_t            state, state_next;
  logic [9:0]        index;
  logic [TILE_W-1:0] buffer;
  logic              change_flag;
  logic              last_tile;

  assign last_tile = (index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_req)  state_next = CLEAR;
        else if (start) state_next = RD_ADDR;
      end
      CLEAR:    if (last_tile) state_next = IDLE;
      RD_ADDR:  state_next = RD_CAP;
      RD_CAP:   state_next = CMP_REQ;
      CMP_REQ:  if (cmp_ready) state_next = CMP_WAIT;
      CMP_WAIT: if (res_valid) state_next = WRITE;
      WRITE:    state_next = last_tile ? SWAP : RD_ADDR;
      SWAP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    tile_addr  = '0;
    read_tile  = 1'b0;
    write_tile = 1'b0;
    reset_tile = 1'b0;
    cmp_valid  = 1'b0;
    case (state)
      CLEAR: begin
        reset_tile = 1'b1;
        tile_addr  = index;
      end
      RD_ADDR, RD_CAP: begin
        read_tile = 1'b1;
        tile_addr = index;
      end
      CMP_REQ: cmp_valid = 1'b1;
      WRITE: begin
        write_tile = 1'b1;
        tile_addr  = index;
      end
      default: ;
    endcase
  end

  assign busy       = (state != IDLE);
  assign cmp_tile   = buffer;
  assign tile_wdata = buffer;

  // Datapath: tile index, tile buffer and per-generation bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      index       <= '0;
      buffer      <= '0;
      change_flag <= 1'b0;
      read_ram_a  <= 1'b0;
      gen_count   <= '0;
      stable      <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req || start) index <= '0;
          if (!clear_req && start) change_flag <= 1'b0;
        end
        CLEAR: begin
          if (last_tile) done <= 1'b1;
          else           index <= index + 10'd1;
        end
        RD_CAP: buffer <= tile_rdata;
        CMP_WAIT: begin
          if (res_valid) begin
            buffer <= res_tile;
            if (res_tile != buffer) change_flag <= 1'b1;
          end
        end
        WRITE: if (!last_tile) index <= index + 10'd1;
        SWAP: begin
          read_ram_a <= ~read_ram_a;
          gen_count  <= gen_count + 16'd1;
          stable     <= ~change_flag;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sand_tile_sequencer.sv
// Bench for sand_tile_sequencer on an 8x8 grid of 4x4 tiles: behavioural two-bank RAM,
// randomized compute stage and a generation-level reference model.
module tb_sand_tile_sequencer;
  localparam int NT = 4;
  localparam int TW = 48;

  logic clk = 1'b0;
  logic rst, start, clear_req, cmp_ready, res_valid;
  logic [TW-1:0] tile_rdata, res_tile, tile_wdata, cmp_tile;
  logic [9:0] tile_addr;
  logic read_tile, write_tile, reset_tile, read_ram_a, cmp_valid, busy, done, stable;
  logic [15:0] gen_count;

  always #5 clk = ~clk;

  sand_tile_sequencer #(.ROWS(8), .COLS(8), .ROWS_TILE(4), .COLS_TILE(4), .CELL_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_req(clear_req), .tile_rdata(tile_rdata),
    .cmp_ready(cmp_ready), .res_valid(res_valid), .res_tile(res_tile), .tile_addr(tile_addr),
    .read_tile(read_tile), .write_tile(write_tile), .reset_tile(reset_tile),
    .read_ram_a(read_ram_a), .tile_wdata(tile_wdata), .cmp_valid(cmp_valid),
    .cmp_tile(cmp_tile), .busy(busy), .done(done), .stable(stable), .gen_count(gen_count)
  );

  int checks = 0;
  int failures = 0;

  // Scenario controls shared with the compute-stage responder
  int mode, stall_tile, stall_req, hold_tile, pass_id, acc_count, stall_left;
  bit rand_ready, abort_resp;
  logic [TW-1:0] mask [NT];

  // Reference bookkeeping
  bit exp_sel;
  int exp_gen;
  logic [TW-1:0] src [NT];

  // Grid RAM model plus bus monitors
  logic [TW-1:0] bank_a [NT], bank_b [NT], load_a [NT], load_b [NT], last_wr [NT];
  logic load_en;
  int wr_cnt [NT];
  int hold_viol = 0, strobe_viol = 0, done_cnt = 0, stall_obs = 0;
  bit prev_wait = 1'b0;
  logic [TW-1:0] prev_tile;

  initial for (int i = 0; i < NT; i++) wr_cnt[i] = 0;

  always @(posedge clk) begin
    if (load_en) for (int i = 0; i < NT; i++) begin bank_a[i] = load_a[i]; bank_b[i] = load_b[i]; end
    if (read_tile) tile_rdata <= read_ram_a ? bank_a[tile_addr[1:0]] : bank_b[tile_addr[1:0]];
    if (write_tile) begin
      wr_cnt[tile_addr[1:0]]++;
      last_wr[tile_addr[1:0]] = tile_wdata;
      if (read_ram_a) bank_b[tile_addr[1:0]] = tile_wdata;
      else            bank_a[tile_addr[1:0]] = tile_wdata;
    end
    if (reset_tile) begin
      if (read_ram_a) bank_b[tile_addr[1:0]] = '0;
      else            bank_a[tile_addr[1:0]] = '0;
    end
    if (!rst) begin
      if (prev_wait) begin
        stall_obs++;
        if (!cmp_valid || cmp_tile !== prev_tile) hold_viol++;
      end
      if (!busy && (read_tile || write_tile || reset_tile || cmp_valid)) strobe_viol++;
      if (cmp_valid && (read_tile || write_tile || reset_tile)) strobe_viol++;
      if (int'(read_tile) + int'(write_tile) + int'(reset_tile) > 1) strobe_viol++;
      if (done) done_cnt++;
    end
    prev_wait = !rst && cmp_valid && !cmp_ready;
    prev_tile = cmp_tile;
  end

  function automatic logic [TW-1:0] fcomp(int k, logic [TW-1:0] t);
    logic [TW-1:0] r;
    r = t;
    case (mode)
      1: if (k == 2) r[2:0] = t[2:0] + 3'd1;
      2: r = t ^ mask[k % NT];
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [TW-1:0] rd_bank(int k);
    return exp_sel ? bank_a[k] : bank_b[k];
  endfunction

  function automatic logic [TW-1:0] wr_bank(int k);
    return exp_sel ? bank_b[k] : bank_a[k];
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[TW-1:0];
  endfunction

  // Compute stage: accepts on cmp_valid&&cmp_ready, answers after a latency
  initial begin
    int k, lat, seen;
    logic [TW-1:0] t;
    cmp_ready = 1'b0; res_valid = 1'b0; res_tile = '0; acc_count = 0; stall_left = 0; seen = 0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (pass_id != seen) begin seen = pass_id; acc_count = 0; stall_left = stall_req; end
      if (stall_left > 0 && acc_count == stall_tile && cmp_valid) begin
        cmp_ready = 1'b0;
        stall_left--;
      end else cmp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmp_valid && cmp_ready && !rst) begin
        k = acc_count; t = cmp_tile; acc_count++;
        @(negedge clk);
        cmp_ready = 1'b0;
        lat = (k == hold_tile) ? 1000 : (rand_ready ? int'($urandom_range(0, 3)) : 0);
        while (lat > 0 && !abort_resp) begin @(negedge clk); lat--; end
        if (!abort_resp) begin res_tile = fcomp(k, t); res_valid = 1'b1; end
      end
    end
  end

  task automatic run_pass(input bit extra_cmds, output int n);
    pass_id++;
    for (int k = 0; k < NT; k++) src[k] = rd_bank(k);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1; n++;
      if (extra_cmds) begin start = (n == 5 || n == 12); clear_req = (n == 8); end
    end
    start = 1'b0; clear_req = 1'b0;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL pass_done got=%0b exp=1 after=%0d", done, n); end
    exp_sel = ~exp_sel;
    exp_gen++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, read_ram_a, stable, read_tile, write_tile, reset_tile, cmp_valid} !== 8'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000000",
        {busy, done, read_ram_a, stable, read_tile, write_tile, reset_tile, cmp_valid});
    end
    checks++;
    if (gen_count !== 16'd0 || tile_addr !== 10'd0) begin
      failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", gen_count, tile_addr);
    end
    checks++;
    if (cmp_tile !== '0 || tile_wdata !== '0) begin
      failures++; $display("FAIL reset_buffer got=%0h/%0h exp=0", cmp_tile, tile_wdata);
    end
    @(negedge clk); rst = 1'b0;
    exp_sel = 1'b0; exp_gen = 0;
  endtask

  task automatic test_clear;
    for (int k = 0; k < NT; k++) begin load_a[k] = rand_tile() | 48'd1; load_b[k] = rand_tile() | 48'd1; end
    @(negedge clk); load_en = 1'b1;
    @(negedge clk); load_en = 1'b0; clear_req = 1'b1;
    @(posedge clk); #1; clear_req = 1'b0;
    for (int i = 0; i < NT; i++) begin
      checks++;
      if (reset_tile !== 1'b1 || tile_addr !== 10'(i) || done !== 1'b0) begin
        failures++; $display("FAIL clear_step%0d got=rt%0b addr%0d done%0b exp=rt1 addr%0d done0",
          i, reset_tile, tile_addr, done, i);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || reset_tile !== 1'b0 || busy !== 1'b0 || read_ram_a !== 1'b0) begin
      failures++; $display("FAIL clear_end got=done%0b rt%0b busy%0b ra%0b exp=1000", done, reset_tile, busy, read_ram_a);
    end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (bank_a[k] !== '0 || bank_b[k] !== load_b[k]) begin
        failures++; $display("FAIL clear_bank%0d got=%0h/%0h exp=0/%0h", k, bank_a[k], bank_b[k], load_b[k]);
      end
    end
  endtask

  task automatic test_echo_pass;
    int n;
    mode = 0; rand_ready = 1'b0;
    run_pass(1'b0, n);
    checks++;
    if (n != 5 * NT + 1) begin failures++; $display("FAIL echo_latency got=%0d exp=%0d", n, 5 * NT + 1); end
    checks++;
    if (read_ram_a !== exp_sel || gen_count !== 16'(exp_gen) || stable !== 1'b1) begin
      failures++; $display("FAIL echo_status got=ra%0b gen%0d st%0b exp=ra%0b gen%0d st1",
        read_ram_a, gen_count, stable, exp_sel, exp_gen);
    end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (rd_bank(k) !== fcomp(k, src[k])) begin
        failures++; $display("FAIL echo_tile%0d got=%0h exp=%0h", k, rd_bank(k), fcomp(k, src[k]));
      end
    end
  endtask

  task automatic test_modify_pass;
    int n, w2;
    logic [TW-1:0] e2;
    mode = 1;
    w2 = wr_cnt[2];
    run_pass(1'b0, n);
    e2 = src[2];
    e2[2:0] = src[2][2:0] + 3'd1;
    checks++;
    if (last_wr[2] !== e2 || wr_cnt[2] != w2 + 1) begin
      failures++; $display("FAIL modify_write got=%0h n%0d exp=%0h n%0d", last_wr[2], wr_cnt[2] - w2, e2, 1);
    end
    checks++;
    if (stable !== 1'b0 || gen_count !== 16'(exp_gen) || read_ram_a !== exp_sel) begin
      failures++; $display("FAIL modify_status got=st%0b gen%0d ra%0b exp=st0 gen%0d ra%0b",
        stable, gen_count, read_ram_a, exp_gen, exp_sel);
    end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (rd_bank(k) !== fcomp(k, src[k])) begin
        failures++; $display("FAIL modify_tile%0d got=%0h exp=%0h", k, rd_bank(k), fcomp(k, src[k]));
      end
    end
    mode = 0;
  endtask

  task automatic test_stall;
    int n, hv, so, wt;
    hv = hold_viol; so = stall_obs; wt = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
    mode = 0; stall_tile = 1; stall_req = 10;
    run_pass(1'b0, n);
    stall_req = 0; stall_tile = -1;
    checks++;
    if (n != 5 * NT + 11) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", n, 5 * NT + 11); end
    checks++;
    if (hold_viol != hv || stall_obs - so < 10) begin
      failures++; $display("FAIL stall_hold got=viol%0d obs%0d exp=viol0 obs>=10", hold_viol - hv, stall_obs - so);
    end
    checks++;
    if (wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3] != wt + NT) begin
      failures++; $display("FAIL stall_writes got=%0d exp=%0d", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3] - wt, NT);
    end
  endtask

  task automatic test_start_clear_collide;
    int n, rc;
    @(negedge clk); start = 1'b1; clear_req = 1'b1;
    @(posedge clk); #1; start = 1'b0; clear_req = 1'b0;
    n = 0; rc = 0;
    while (!done && n < 50) begin
      if (reset_tile) rc++;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (rc != NT || done !== 1'b1) begin failures++; $display("FAIL collide_clear got=rt%0d done%0b exp=rt%0d done1", rc, done, NT); end
    checks++;
    if (gen_count !== 16'(exp_gen) || read_ram_a !== exp_sel) begin
      failures++; $display("FAIL collide_status got=gen%0d ra%0b exp=gen%0d ra%0b", gen_count, read_ram_a, exp_gen, exp_sel);
    end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (wr_bank(k) !== '0) begin failures++; $display("FAIL collide_bank%0d got=%0h exp=0", k, wr_bank(k)); end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL collide_start_dropped got=busy%0b exp=0", busy); end
  endtask

  task automatic test_start_during_pass;
    int n, dc;
    mode = 0;
    dc = done_cnt;
    run_pass(1'b1, n);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (n != 5 * NT + 1 || busy !== 1'b0 || done_cnt != dc + 1) begin
      failures++; $display("FAIL midpass_cmds got=n%0d busy%0b dones%0d exp=n%0d busy0 dones1", n, busy, done_cnt - dc, 5 * NT + 1);
    end
    checks++;
    if (gen_count !== 16'(exp_gen)) begin failures++; $display("FAIL midpass_gen got=%0d exp=%0d", gen_count, exp_gen); end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (rd_bank(k) !== fcomp(k, src[k])) begin
        failures++; $display("FAIL midpass_tile%0d got=%0h exp=%0h", k, rd_bank(k), fcomp(k, src[k]));
      end
    end
  endtask

  task automatic test_random_passes;
    int n;
    bit exp_stable;
    mode = 2; rand_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < NT; k++) mask[k] = (p % 3 == 0 || $urandom_range(0, 2) == 0) ? '0 : rand_tile();
      run_pass(1'b0, n);
      exp_stable = 1'b1;
      for (int k = 0; k < NT; k++) begin
        if (fcomp(k, src[k]) !== src[k]) exp_stable = 1'b0;
        checks++;
        if (rd_bank(k) !== fcomp(k, src[k])) begin
          failures++; $display("FAIL rand%0d_tile%0d got=%0h exp=%0h", p, k, rd_bank(k), fcomp(k, src[k]));
        end
      end
      checks++;
      if (stable !== exp_stable || gen_count !== 16'(exp_gen) || read_ram_a !== exp_sel) begin
        failures++; $display("FAIL rand%0d_status got=st%0b gen%0d ra%0b exp=st%0b gen%0d ra%0b",
          p, stable, gen_count, read_ram_a, exp_stable, exp_gen, exp_sel);
      end
    end
    mode = 0; rand_ready = 1'b0;
  endtask

  task automatic test_monitors;
    checks++;
    if (strobe_viol != 0) begin failures++; $display("FAIL strobe_rules got=%0d exp=0", strobe_viol); end
    checks++;
    if (hold_viol != 0) begin failures++; $display("FAIL cmp_hold got=%0d exp=0", hold_viol); end
  endtask

  task automatic test_reset_midpass;
    int n, w2;
    mode = 0; rand_ready = 1'b0; hold_tile = 2; stall_req = 0;
    w2 = wr_cnt[2];
    pass_id++;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; n = 0;
    while (acc_count < 3 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (acc_count != 3 || busy !== 1'b1 || cmp_valid !== 1'b0) begin
      failures++; $display("FAIL abort_reach got=acc%0d busy%0b cv%0b exp=acc3 busy1 cv0", acc_count, busy, cmp_valid);
    end
    @(negedge clk); rst = 1'b1; abort_resp = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, read_ram_a, stable, read_tile, write_tile, reset_tile, cmp_valid} !== 8'b0) begin
      failures++; $display("FAIL abort_flags got=%b exp=00000000",
        {busy, done, read_ram_a, stable, read_tile, write_tile, reset_tile, cmp_valid});
    end
    checks++;
    if (gen_count !== 16'd0 || tile_addr !== 10'd0 || cmp_tile !== '0 || tile_wdata !== '0) begin
      failures++; $display("FAIL abort_values got=gen%0d addr%0d tile%0h exp=0", gen_count, tile_addr, cmp_tile);
    end
    @(negedge clk); rst = 1'b0; hold_tile = -1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt[2] != w2 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_no_write got=writes%0d busy%0b exp=0 0", wr_cnt[2] - w2, busy);
    end
    abort_resp = 1'b0;
    exp_sel = 1'b0; exp_gen = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear_req = 1'b0; load_en = 1'b0;
    mode = 0; rand_ready = 1'b0; stall_req = 0; stall_tile = -1; hold_tile = -1;
    abort_resp = 1'b0; pass_id = 0;
    for (int k = 0; k < NT; k++) mask[k] = '0;
    test_reset();
    test_clear();
    test_echo_pass();
    test_modify_pass();
    test_stall();
    test_start_clear_collide();
    test_start_during_pass();
    test_random_passes();
    test_monitors();
    test_reset_midpass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
